// File: rtl/readout_tx_pkg.sv
// Shared opcode, state and width definitions for the readout TX program sequencer.
package readout_tx_pkg;

  localparam int PC_WIDTH_DEF  = 11;
  localparam int OP_WIDTH      = 3;
  localparam int CNT_WIDTH_DEF = 16;

  localparam logic [OP_WIDTH-1:0] OP_NEXT    = 3'd0;
  localparam logic [OP_WIDTH-1:0] OP_JUMP    = 3'd1;
  localparam logic [OP_WIDTH-1:0] OP_SETLOOP = 3'd2;
  localparam logic [OP_WIDTH-1:0] OP_LOOP    = 3'd3;
  localparam logic [OP_WIDTH-1:0] OP_WAIT    = 3'd4;
  localparam logic [OP_WIDTH-1:0] OP_HALT    = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } seq_state_e;

endpackage

// File: rtl/readout_tx_wait_timer.sv
// Down-counter for WAIT instructions: clear beats load beats decrement, saturates at zero.
module readout_tx_wait_timer #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 dec,
  output logic                 zero
);

  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (dec && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/readout_tx_seq.sv
// Readout TX program sequencer: decodes the instruction at PC and steers the PC register
// through sequential, jump, counted-loop, timed-wait and halt flow.
module readout_tx_seq #(
  parameter int PC_WIDTH  = readout_tx_pkg::PC_WIDTH_DEF,
  parameter int OP_WIDTH  = readout_tx_pkg::OP_WIDTH,
  parameter int CNT_WIDTH = readout_tx_pkg::CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PC_WIDTH-1:0]  start_addr,
  input  logic                 abort,
  input  logic [PC_WIDTH-1:0]  PC,
  input  logic                 instr_valid,
  input  logic [OP_WIDTH-1:0]  instr_op,
  input  logic [PC_WIDTH-1:0]  instr_target,
  input  logic [CNT_WIDTH-1:0] instr_operand,
  output logic                 update_pc,
  output logic [PC_WIDTH-1:0]  next_PC,
  output logic                 busy,
  output logic                 done
);
  import readout_tx_pkg::*;

  seq_state_e           state;
  logic [CNT_WIDTH-1:0] loop_cnt;
  logic [PC_WIDTH-1:0]  pc_inc;
  logic                 tmr_clr, tmr_load, tmr_dec, tmr_zero;
  logic [CNT_WIDTH-1:0] tmr_val;

  assign pc_inc = PC + 1'b1;
  assign busy   = (state != IDLE);

  readout_tx_wait_timer #(.CNT_WIDTH(CNT_WIDTH)) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // PC steering is Mealy so the PC register can take the new address on this same edge.
  always_comb begin
    update_pc = 1'b0;
    next_PC   = '0;
    tmr_clr   = 1'b0;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    tmr_val   = '0;
    if (abort) begin
      tmr_clr = 1'b1;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          update_pc = 1'b1;
          next_PC   = start_addr;
        end
        RUN: if (instr_valid) begin
          unique case (instr_op)
            OP_JUMP: begin
              update_pc = 1'b1;
              next_PC   = instr_target;
            end
            OP_LOOP: begin
              update_pc = 1'b1;
              next_PC   = (loop_cnt != '0) ? instr_target : pc_inc;
            end
            OP_WAIT: begin
              if (instr_operand == '0) begin
                update_pc = 1'b1;
                next_PC   = pc_inc;
              end else begin
                tmr_load = 1'b1;
                tmr_val  = instr_operand - 1'b1;
              end
            end
            OP_HALT: ;
            default: begin
              update_pc = 1'b1;
              next_PC   = pc_inc;
            end
          endcase
        end
        WAIT: begin
          if (tmr_zero) begin
            update_pc = 1'b1;
            next_PC   = pc_inc;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      loop_cnt <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: if (start) state <= RUN;
          RUN: if (instr_valid) begin
            unique case (instr_op)
              OP_SETLOOP: loop_cnt <= instr_operand;
              OP_LOOP:    if (loop_cnt != '0) loop_cnt <= loop_cnt - 1'b1;
              OP_WAIT:    if (instr_operand != '0) state <= WAIT;
              OP_HALT: begin
                state <= IDLE;
                done  <= 1'b1;
              end
              default: ;
            endcase
          end
          WAIT: if (tmr_zero) state <= RUN;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_readout_tx_seq.sv
// Randomized and directed bench for readout_tx_seq against a cycle-level reference model.
module tb_readout_tx_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, instr_valid;
  logic [10:0] start_addr;
  logic [10:0] pc;
  logic [2:0]  instr_op;
  logic [10:0] instr_target;
  logic [15:0] instr_operand;
  logic        update_pc, busy, done;
  logic [10:0] next_PC;

  logic [2:0]  prog_op  [2048];
  logic [10:0] prog_tgt [2048];
  logic [15:0] prog_opd [2048];

  int n_cmp = 0;
  int n_bad = 0;
  int hi_cnt [2048];
  int lo_cnt [2048];

  // reference model state
  bit m_busy, m_wait, m_done;
  int m_left, m_loop;

  always #5 clk = ~clk;

  assign instr_op      = prog_op[pc];
  assign instr_target  = prog_tgt[pc];
  assign instr_operand = prog_opd[pc];

  readout_tx_seq dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .start_addr    (start_addr),
    .abort         (abort),
    .PC            (pc),
    .instr_valid   (instr_valid),
    .instr_op      (instr_op),
    .instr_target  (instr_target),
    .instr_operand (instr_operand),
    .update_pc     (update_pc),
    .next_PC       (next_PC),
    .busy          (busy),
    .done          (done)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_wait = 0; m_done = 0; m_left = 0; m_loop = 0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 2048; i++) begin
      prog_op[i] = 3'd0; prog_tgt[i] = '0; prog_opd[i] = '0;
      hi_cnt[i] = 0; lo_cnt[i] = 0;
    end
  endtask

  task automatic put(input int a, input int op, input int tgt, input int opd);
    prog_op[a] = 3'(op); prog_tgt[a] = 11'(tgt); prog_opd[a] = 16'(opd);
  endtask

  // One clock: drive inputs, predict, compare, then advance model and PC register.
  task automatic step(input bit s, input logic [10:0] sa, input bit ab, input bit v);
    logic eu; logic [10:0] en; bit nb, nw, nd; int nl, nlp;
    @(negedge clk);
    start = s; start_addr = sa; abort = ab; instr_valid = v;
    #1;
    eu = 0; en = '0; nb = m_busy; nw = m_wait; nl = m_left; nlp = m_loop; nd = 0;
    if (ab) begin
      nb = 0; nw = 0; nl = 0;
    end else if (!m_busy) begin
      if (s) begin eu = 1; en = sa; nb = 1; end
    end else if (m_wait) begin
      if (m_left > 0) nl = m_left - 1;
      else begin eu = 1; en = pc + 11'd1; nw = 0; end
    end else if (v) begin
      case (int'(prog_op[pc]))
        1: begin eu = 1; en = prog_tgt[pc]; end
        2: begin eu = 1; en = pc + 11'd1; nlp = int'(prog_opd[pc]); end
        3: begin
          eu = 1;
          if (m_loop != 0) begin en = prog_tgt[pc]; nlp = m_loop - 1; end
          else en = pc + 11'd1;
        end
        4: if (prog_opd[pc] == 0) begin eu = 1; en = pc + 11'd1; end
           else begin nw = 1; nl = int'(prog_opd[pc]) - 1; end
        5: begin nb = 0; nd = 1; end
        default: begin eu = 1; en = pc + 11'd1; end
      endcase
    end
    chk("update_pc", 32'(update_pc), 32'(eu));
    chk("next_PC",   32'(next_PC),   32'(en));
    chk("busy",      32'(busy),      32'(m_busy));
    chk("done",      32'(done),      32'(m_done));
    if (busy) begin
      if (update_pc) hi_cnt[pc]++;
      else           lo_cnt[pc]++;
    end
    @(posedge clk); #1;
    if (eu) pc = en;
    m_busy = nb; m_wait = nw; m_left = nl; m_loop = nlp; m_done = nd;
  endtask

  task automatic run(input int budget);
    int n = 0;
    while (m_busy && n < budget) begin step(0, '0, 0, 1); n++; end
    chk("run_budget", 32'(m_busy), 32'd0);
    step(0, '0, 0, 1);
    step(0, '0, 0, 1);
  endtask

  initial begin
    rst = 1; start = 0; abort = 0; instr_valid = 0; start_addr = '0; pc = '0;
    clear_prog();
    model_reset();
    #3;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_upd",  32'(update_pc), 0);
    chk("rst_npc",  32'(next_PC), 0);
    @(negedge clk); #1 rst = 0;

    // linear program
    put(11'h010, 0, 0, 0); put(11'h011, 0, 0, 0); put(11'h012, 5, 0, 0);
    step(1, 11'h010, 0, 1);
    run(20);
    chk("lin_pc", 32'(pc), 32'h012);
    chk("lin_hits", 32'(hi_cnt[11'h010] + hi_cnt[11'h011]), 2);

    // counted loop
    clear_prog();
    put(0, 2, 0, 3); put(1, 0, 0, 0); put(2, 3, 1, 0); put(3, 5, 0, 0);
    step(1, 11'h000, 0, 1);
    run(40);
    chk("loop_body_exec", 32'(hi_cnt[1]), 4);
    chk("loop_branches", 32'(hi_cnt[2]), 4);
    chk("loop_pc", 32'(pc), 3);

    // WAIT 5 then WAIT 0
    clear_prog();
    put(11'h020, 4, 0, 5); put(11'h021, 4, 0, 0); put(11'h022, 5, 0, 0);
    step(1, 11'h020, 0, 1);
    run(40);
    chk("wait5_low", 32'(lo_cnt[11'h020]), 5);
    chk("wait0_low", 32'(lo_cnt[11'h021]), 0);
    chk("wait_pc", 32'(pc), 32'h022);

    // wrap and jump
    clear_prog();
    put(11'h7FF, 0, 0, 0); put(0, 1, 11'h155, 0); put(11'h155, 5, 0, 0);
    step(1, 11'h7FF, 0, 1);
    run(20);
    chk("wrap_jump_pc", 32'(pc), 32'h155);

    // abort during a long wait
    clear_prog();
    put(11'h030, 4, 0, 100);
    step(1, 11'h030, 0, 1);
    repeat (4) step(0, '0, 0, 1);
    step(0, '0, 1, 1);
    repeat (3) step(0, '0, 0, 1);
    chk("abort_pc", 32'(pc), 32'h030);
    chk("abort_idle", 32'(busy), 0);

    // start while running, then a 3-cycle stall
    clear_prog();
    put(11'h050, 0, 0, 0); put(11'h051, 0, 0, 0); put(11'h052, 0, 0, 0); put(11'h053, 5, 0, 0);
    step(1, 11'h050, 0, 1);
    step(0, '0, 0, 1);
    step(1, 11'h123, 0, 1);
    repeat (3) step(0, '0, 0, 0);
    run(20);
    chk("stall_low", 32'(lo_cnt[11'h052]), 3);
    chk("stall_pc", 32'(pc), 32'h053);

    // async reset mid-loop, then clean restart with loop_cnt=0
    clear_prog();
    put(0, 2, 0, 50); put(1, 0, 0, 0); put(2, 3, 1, 0);
    put(11'h040, 3, 11'h010, 0); put(11'h041, 5, 0, 0);
    step(1, 11'h000, 0, 1);
    repeat (8) step(0, '0, 0, 1);
    #2 rst = 1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_upd",  32'(update_pc), 0);
    model_reset();
    #1 rst = 0;
    step(1, 11'h040, 0, 1);
    run(20);
    chk("arst_restart_pc", 32'(pc), 32'h041);

    // randomized programs and control
    for (int i = 0; i < 2048; i++)
      put(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 2047)), int'($urandom_range(0, 7)));
    for (int k = 0; k < 3000; k++)
      step(($urandom_range(0, 3) == 0), 11'($urandom_range(0, 2047)),
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
